// File: rtl/spi_flash_pkg.sv
// -----------------------------------------------------------------------------
// spi_flash_pkg
// Shared constants and types for the SPI NOR flash word reader.
//   - READ / FAST_READ : flash command opcodes
//   - state_t          : transaction sequencer states
//   - *_BITS           : frame segment lengths on the wire
// -----------------------------------------------------------------------------
package spi_flash_pkg;

  localparam logic [7:0] READ      = 8'h03;
  localparam logic [7:0] FAST_READ = 8'h0B;

  // Opcode plus 24-bit address, optional dummy byte, then one data word.
  localparam int CMD_ADDR_BITS = 32;
  localparam int DUMMY_BITS    = 8;
  localparam int DATA_BITS     = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/spi_flash_reader_clk_div.sv
// -----------------------------------------------------------------------------
// spi_clk_div
// Half-period phase counter for the SPI clock. While enabled it counts CLK_DIV
// clk cycles per half period and strikes rise_en at the end of each low phase
// and fall_en at the end of each high phase (one clk cycle each). Dropping
// enable restarts the count so every frame begins with a full low phase.
// Ports:
//   clk     in  system clock
//   reset   in  asynchronous active-high reset
//   enable  in  count while high; counter and phase cleared while low
//   rise_en out one-cycle strike: SPI clock should go high on this edge
//   fall_en out one-cycle strike: SPI clock should go low on this edge
// -----------------------------------------------------------------------------
module spi_clk_div #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic rise_en,
  output logic fall_en
);

  localparam logic [7:0] LAST_COUNT = 8'(CLK_DIV - 1);

  logic [7:0] count_reg;
  logic       phase_reg;  // 0: low half period, 1: high half period
  logic       tick;

  assign tick    = enable && (count_reg == LAST_COUNT);
  assign rise_en = tick && !phase_reg;
  assign fall_en = tick && phase_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= 8'd0;
      phase_reg <= 1'b0;
    end else if (!enable) begin
      count_reg <= 8'd0;
      phase_reg <= 1'b0;
    end else if (tick) begin
      count_reg <= 8'd0;
      phase_reg <= !phase_reg;
    end else begin
      count_reg <= count_reg + 8'd1;
    end
  end

endmodule

// File: rtl/spi_flash_reader.sv
// -----------------------------------------------------------------------------
// spi_flash_reader
// Turns a CPU word-read strobe into a SPI NOR flash READ transaction (mode 0,
// MSB first) and returns one little-endian 32-bit word per request. Only one
// request is in flight; strobes while busy are dropped.
// Build option: define SPI_FLASH_FAST_READ_EN to issue FAST_READ (0x0B) with
// 8 dummy bits after the address; otherwise plain READ (0x03).
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous active-high reset
//   rstrb        in   read request, sampled only while idle
//   word_address in   [19:0] flash word address (byte address = {wa, 2'b00})
//   rdata        out  [31:0] last read word, held until the next completion
//   rvalid       out  one-cycle pulse when rdata updates
//   rbusy        out  transaction in progress, including the chip-select gap
//   spi_cs_n     out  flash chip select, active low
//   spi_clk      out  SPI clock, idles low
//   spi_mosi     out  command/address to flash
//   spi_miso     in   data from flash
// -----------------------------------------------------------------------------
module spi_flash_reader
  import spi_flash_pkg::*;
#(
  parameter int CLK_DIV = 1,
  parameter int CS_GAP  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rstrb,
  input  logic [19:0] word_address,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        rbusy,
  output logic        spi_cs_n,
  output logic        spi_clk,
  output logic        spi_mosi,
  input  logic        spi_miso
);

`ifdef SPI_FLASH_FAST_READ_EN
  localparam logic [7:0] OPCODE     = FAST_READ;
  localparam int         TOTAL_BITS = CMD_ADDR_BITS + DUMMY_BITS + DATA_BITS;
`else
  localparam logic [7:0] OPCODE     = READ;
  localparam int         TOTAL_BITS = CMD_ADDR_BITS + DATA_BITS;
`endif

  localparam logic [6:0] LAST_BIT   = 7'(TOTAL_BITS - 1);
  localparam logic [6:0] FIRST_DATA = 7'(TOTAL_BITS - DATA_BITS);
  localparam logic [3:0] GAP_LAST   = 4'(CS_GAP - 1);

  state_t      state_reg, state_next;
  logic [31:0] frame_reg, frame_next;  // remaining command bits, next bit at [31]
  logic [31:0] data_reg,  data_next;
  logic [6:0]  bit_reg,   bit_next;
  logic [3:0]  gap_reg,   gap_next;
  logic [31:0] rdata_reg, rdata_next;
  logic        rvalid_reg, rvalid_next;
  logic        rbusy_reg,  rbusy_next;
  logic        cs_n_reg,   cs_n_next;
  logic        sclk_reg,   sclk_next;
  logic        mosi_reg,   mosi_next;

  logic rise_en;
  logic fall_en;

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk     (clk),
    .reset   (reset),
    .enable  (state_reg == SHIFT),
    .rise_en (rise_en),
    .fall_en (fall_en)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      frame_reg  <= 32'd0;
      data_reg   <= 32'd0;
      bit_reg    <= 7'd0;
      gap_reg    <= 4'd0;
      rdata_reg  <= 32'd0;
      rvalid_reg <= 1'b0;
      rbusy_reg  <= 1'b0;
      cs_n_reg   <= 1'b1;
      sclk_reg   <= 1'b0;
      mosi_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      frame_reg  <= frame_next;
      data_reg   <= data_next;
      bit_reg    <= bit_next;
      gap_reg    <= gap_next;
      rdata_reg  <= rdata_next;
      rvalid_reg <= rvalid_next;
      rbusy_reg  <= rbusy_next;
      cs_n_reg   <= cs_n_next;
      sclk_reg   <= sclk_next;
      mosi_reg   <= mosi_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    frame_next  = frame_reg;
    data_next   = data_reg;
    bit_next    = bit_reg;
    gap_next    = gap_reg;
    rdata_next  = rdata_reg;
    rvalid_next = 1'b0;
    rbusy_next  = rbusy_reg;
    cs_n_next   = cs_n_reg;
    sclk_next   = sclk_reg;
    mosi_next   = mosi_reg;

    unique case (state_reg)
      IDLE: begin
        if (rstrb) begin
          // Bit 0 goes straight onto mosi; the register keeps the rest,
          // left-justified, and fills with zeros so dummy/data bits send 0.
          mosi_next  = OPCODE[7];
          frame_next = {OPCODE[6:0], 2'b00, word_address, 2'b00, 1'b0};
          cs_n_next  = 1'b0;
          rbusy_next = 1'b1;
          bit_next   = 7'd0;
          state_next = SHIFT;
        end
      end

      SHIFT: begin
        if (rise_en) begin
          sclk_next = 1'b1;
          if (bit_reg >= FIRST_DATA) begin
            data_next = {data_reg[30:0], spi_miso};
          end
        end else if (fall_en) begin
          sclk_next = 1'b0;
          if (bit_reg == LAST_BIT) begin
            // First byte off the wire is the lowest-addressed byte.
            cs_n_next   = 1'b1;
            mosi_next   = 1'b0;
            rdata_next  = {data_reg[7:0], data_reg[15:8],
                           data_reg[23:16], data_reg[31:24]};
            rvalid_next = 1'b1;
            gap_next    = 4'd0;
            state_next  = GAP;
          end else begin
            mosi_next  = frame_reg[31];
            frame_next = {frame_reg[30:0], 1'b0};
            bit_next   = bit_reg + 7'd1;
          end
        end
      end

      GAP: begin
        if (gap_reg == GAP_LAST) begin
          rbusy_next = 1'b0;
          state_next = IDLE;
        end else begin
          gap_next = gap_reg + 4'd1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign rdata    = rdata_reg;
  assign rvalid   = rvalid_reg;
  assign rbusy    = rbusy_reg;
  assign spi_cs_n = cs_n_reg;
  assign spi_clk  = sclk_reg;
  assign spi_mosi = mosi_reg;

endmodule

// File: tb/tb_spi_flash_reader.sv
// -----------------------------------------------------------------------------
// tb_spi_flash_reader
// Drives directed and random read strobes into spi_flash_reader, emulates a
// SPI NOR flash on the pins, and scores every completed word against a
// reference built from the flash contents and the request timeline.
// -----------------------------------------------------------------------------
module tb_spi_flash_reader;

  localparam int CLK_DIV = 3;
  localparam int CS_GAP  = 2;

`ifdef SPI_FLASH_FAST_READ_EN
  localparam logic [7:0] OP    = 8'h0B;
  localparam int         TOTAL = 72;
`else
  localparam logic [7:0] OP    = 8'h03;
  localparam int         TOTAL = 64;
`endif
  localparam int DSTART = TOTAL - 32;
  localparam int LAT    = 2 * CLK_DIV * TOTAL;  // accept edge -> completion edge

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rstrb = 1'b0;
  logic [19:0] word_address = 20'd0;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rbusy;
  logic        spi_cs_n;
  logic        spi_clk;
  logic        spi_mosi;
  logic        spi_miso = 1'b0;

  spi_flash_reader #(
    .CLK_DIV (CLK_DIV),
    .CS_GAP  (CS_GAP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rstrb        (rstrb),
    .word_address (word_address),
    .rdata        (rdata),
    .rvalid       (rvalid),
    .rbusy        (rbusy),
    .spi_cs_n     (spi_cs_n),
    .spi_clk      (spi_clk),
    .spi_mosi     (spi_mosi),
    .spi_miso     (spi_miso)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Flash contents: a few known words, pseudo-random bytes elsewhere.
  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    case (a)
      24'h000010: return 8'hEF;
      24'h000011: return 8'hBE;
      24'h000012: return 8'hAD;
      24'h000013: return 8'hDE;
      24'h3FFFFC: return 8'h11;
      24'h3FFFFD: return 8'h22;
      24'h3FFFFE: return 8'h33;
      24'h3FFFFF: return 8'h44;
      default:    return (a[7:0] * 8'd37) ^ a[15:8] ^ a[23:16] ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [31:0] exp_word(input logic [19:0] wa);
    logic [23:0] b;
    b = {2'b00, wa, 2'b00};
    return {flash_byte(b + 24'd3), flash_byte(b + 24'd2),
            flash_byte(b + 24'd1), flash_byte(b)};
  endfunction

  // ---------------- flash pin model (mode 0) ----------------
  logic [127:0] mosi_bits = '0;
  int           rise_cnt = 0;
  logic [23:0]  f_addr = '0;
  int           fj;
  logic [7:0]   fbyte;

  always @(negedge spi_cs_n) begin
    rise_cnt  = 0;
    mosi_bits = '0;
  end

  always @(posedge spi_clk) begin
    mosi_bits = {mosi_bits[126:0], spi_mosi};
    rise_cnt++;
    if (rise_cnt == 32) f_addr = mosi_bits[23:0];
  end

  always @(negedge spi_clk) begin
    if (rise_cnt >= DSTART && rise_cnt < TOTAL) begin
      fj       = rise_cnt - DSTART;
      fbyte    = flash_byte(f_addr + 24'(fj / 8));
      spi_miso = fbyte[7 - (fj % 8)];
    end else begin
      spi_miso = 1'b0;
    end
  end

  // ---------------- request timeline model + scoreboard ----------------
  typedef struct {
    logic [19:0] wa;
    logic [31:0] data;
    int          edge_n;
  } exp_t;

  exp_t sb[$];
  exp_t new_e;
  exp_t got_e;
  int   acc_edge = 0;
  int   next_accept = 0;
  bit   have_acc = 1'b0;
  bit   checking = 1'b0;

  always @(posedge clk) begin
    if (!reset) begin
      cyc++;
      if (rstrb && cyc >= next_accept) begin
        new_e.wa     = word_address;
        new_e.data   = exp_word(word_address);
        new_e.edge_n = cyc + LAT;
        sb.push_back(new_e);
        acc_edge    = cyc;
        have_acc    = 1'b1;
        next_accept = cyc + LAT + CS_GAP + 1;
      end
    end
  end

  bit           e_busy, e_csn, e_rv;
  logic [127:0] e_mosi;

  always @(negedge clk) begin
    if (checking && !reset) begin
      e_busy = have_acc && cyc >= acc_edge && cyc < acc_edge + LAT + CS_GAP;
      e_csn  = !(have_acc && cyc >= acc_edge && cyc < acc_edge + LAT);
      e_rv   = have_acc && cyc == acc_edge + LAT;
      check("rbusy", rbusy, e_busy);
      check("spi_cs_n", spi_cs_n, e_csn);
      check("rvalid_timing", rvalid, e_rv);
      if (rvalid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rvalid: got rdata %h want no completion (cycle %0d)", rdata, cyc);
        end else begin
          got_e  = sb.pop_front();
          e_mosi = 128'({OP, 2'b00, got_e.wa, 2'b00}) << (TOTAL - 32);
          check("rdata", rdata, got_e.data);
          check("complete_cycle", cyc, got_e.edge_n);
          check("mosi_stream", mosi_bits, e_mosi);
          check("sclk_rises", rise_cnt, TOTAL);
          $display("txn wa=%05h rdata=%08h cycle=%0d", got_e.wa, rdata, cyc);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic pulse(input logic [19:0] a);
    @(negedge clk); #1;
    rstrb = 1'b1;
    word_address = a;
    @(negedge clk); #1;
    rstrb = 1'b0;
    word_address = 20'($urandom);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (cyc + 1 < next_accept && k < 5000) begin
      @(negedge clk);
      k++;
    end
    check("wait_idle_bound", k >= 5000, 1'b0);
  endtask

  task automatic wait_cycle(input int n);
    int k = 0;
    while (cyc < n && k < 5000) begin
      @(negedge clk);
      k++;
    end
  endtask

  function automatic logic [19:0] pick_addr();
    case ($urandom_range(0, 7))
      0:       return 20'd4;
      1:       return 20'hFFFFF;
      2:       return 20'd0;
      default: return 20'($urandom);
    endcase
  endfunction

  int base;

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_cs_n", spi_cs_n, 1'b1);
    check("reset_spi_clk", spi_clk, 1'b0);
    check("reset_mosi", spi_mosi, 1'b0);
    check("reset_rbusy", rbusy, 1'b0);
    check("reset_rvalid", rvalid, 1'b0);
    check("reset_rdata", rdata, 32'd0);
    #1 reset = 1'b0;
    checking = 1'b1;

    // Basic read of word 4 (bytes EF BE AD DE)
    pulse(20'd4);
    wait_idle();

    // Busy rejection: strobes for word 8 during the transfer are dropped
    pulse(20'd4);
    base = acc_edge;
    wait_cycle(base + 10);
    pulse(20'd8);
    wait_cycle(base + 60);
    pulse(20'd8);
    wait_idle();
    pulse(20'd8);
    wait_idle();

    // Reset around bit 20 of a transfer
    pulse(20'd4);
    wait_cycle(acc_edge + 20 * 2 * CLK_DIV + 1);
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    check("midreset_cs_n", spi_cs_n, 1'b1);
    check("midreset_spi_clk", spi_clk, 1'b0);
    check("midreset_rbusy", rbusy, 1'b0);
    check("midreset_rdata", rdata, 32'd0);
    check("midreset_rvalid", rvalid, 1'b0);
    sb.delete();
    have_acc    = 1'b0;
    next_accept = 0;
    @(negedge clk); #1;
    reset = 1'b0;
    pulse(20'd4);
    wait_idle();

    // Top of the address space
    pulse(20'hFFFFF);
    wait_idle();

    // Strobe held high across two frames, address changing every cycle
    for (int i = 0; i < 2 * (LAT + CS_GAP + 1) + 4; i++) begin
      @(negedge clk); #1;
      rstrb = 1'b1;
      word_address = (i == 0) ? 20'hFFFFF : 20'($urandom);
    end
    @(negedge clk); #1;
    rstrb = 1'b0;
    wait_idle();

    // Random traffic
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk); #1;
      rstrb = ($urandom_range(0, 15) == 0);
      word_address = pick_addr();
    end
    @(negedge clk); #1;
    rstrb = 1'b0;

    begin
      int k = 0;
      while (sb.size() > 0 && k < 3 * LAT) begin
        @(negedge clk);
        k++;
      end
      @(negedge clk);
      check("drain_pending", sb.size(), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: got no finish want finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
